memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
// MEM stage plus MEM/WB pipeline register; sits between EX/MEM and writeback_stage.
// Issues loads/stores to data memory over a req/ack handshake and stalls upstream while waiting.
// Formats load data (byte/half, signed/unsigned) and registers alu_result, memory_data,
// wb_sel, reg_write and rd for writeback.
// PARAMETERS
// ACK_TIMEOUT  255  max cycles in WAIT before abort; 0 = no timeout
// PORTS
// clk            in   1   clock, rising edge
// rst            in   1   asynchronous reset, active-high
// ex_valid       in   1   EX/MEM holds a valid instruction
// ex_reg_write   in   1   instruction writes rd
// ex_wb_sel      in   2   00 ALU, 01 memory
// ex_rd          in   5   destination register
// ex_alu_result  in   32  ALU result / effective address
// ex_store_data  in   32  rs2 value for stores
// ex_mem_read    in   1   load
// ex_mem_write   in   1   store
// ex_funct3      in   3   access size/sign (RV32I encoding)
// flush          in   1   kill instruction in EX/MEM
// mem_stall      out  1   hold EX/MEM and earlier stages
// dmem_req       out  1   memory request, held until ack
// dmem_we        out  1   1 = store
// dmem_addr      out  32  word-aligned address ({addr[31:2],2'b00})
// dmem_wdata     out  32  lane-replicated store data
// dmem_wstrb     out  4   byte enables (0000 on loads)
// dmem_ack       in   1   request complete; dmem_rdata valid when load
// dmem_rdata     in   32  load word
// wb_valid       out  1   MEM/WB holds a valid instruction
// reg_write      out  1   to writeback; gated with wb_valid
// wb_sel         out  2   to writeback
// rd             out  5   to writeback
// alu_result     out  32  to writeback
// memory_data    out  32  formatted load data
// mem_misaligned out  1   1-cycle pulse with wb_valid: misaligned access, no memory op
// mem_fault      out  1   1-cycle pulse with wb_valid: ACK_TIMEOUT expired
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; timeout counter 0. Reset mid-WAIT drops dmem_req at once.
// - memop = ex_valid & !flush & (ex_mem_read|ex_mem_write). Misaligned = (LH/LHU/SH & addr[0])
//   | (LW/SW & addr[1:0]!=0). funct3 011/110/111 are treated as word.
// - Non-memory op, misaligned op, or bubble in IDLE: MEM/WB loads next edge (1-cycle latency).
//   wb_valid = ex_valid & !flush. Misaligned: reg_write=0, mem_misaligned=1, no dmem_req.
// - FSM IDLE: aligned memop -> latch addr/size/rd/ctl, dmem_req<=1, go WAIT; MEM/WB gets bubble.
// - FSM WAIT: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb are held stable.
//   On dmem_ack: dmem_req<=0; MEM/WB loads the op with wb_valid=1; go IDLE.
//   Load: memory_data = formatted rdata. Store: reg_write=0.
//   Otherwise the bubble is held and the counter increments.
// - Timeout: counter reaching ACK_TIMEOUT in WAIT -> drop req, go IDLE, wb_valid=1,
//   reg_write=0, mem_fault=1.
// - Minimum memory-op latency: 2 cycles (accept, then ack on the earliest following edge).
// - mem_stall = (IDLE & aligned memop) | (WAIT & !dmem_ack & !timeout). Combinational.
//   Upstream holds ex_* stable while it is high.
// - flush in IDLE: op discarded and wb_valid=0.
//   flush in WAIT: the bus transaction still completes; wb_valid=0 on completion.
// - Load format: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; sign- or zero-extend.
// - Store: SB wstrb=0001<<addr[1:0], wdata={4{b}}; SH 0011<<{addr[1],0}, {2{h}}; SW 1111.
// - dmem_ack outside WAIT is ignored.
// TESTING
// - ALU op rd=5, alu=0x1234, wb_sel=00 -> next cycle wb_valid=1, reg_write=1, alu_result=0x1234,
//   no dmem_req, mem_stall=0.
// - LB at 0x1003 with rdata=0x80FF_FF00, ack 1 cycle after req -> mem_stall 2 cycles,
//   memory_data=0xFFFF_FF80; same with LBU -> 0x0000_0080.
// - SH 0xABCD at 0x2002 -> dmem_addr=0x2000, wstrb=1100, wdata=0xABCD_ABCD, dmem_we=1;
//   on ack, reg_write=0 and wb_valid=1.
// - LW at 0x3001 -> no dmem_req, mem_misaligned=1, reg_write=0, single-cycle pass.
// - Load with ack withheld, ACK_TIMEOUT=4 -> dmem_req high 4 cycles then 0,
//   mem_fault=1, stall released.
// - flush asserted during WAIT, then ack -> wb_valid=0; assert rst during WAIT ->
//   dmem_req=0 immediately and state IDLE.

Source files
------------

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface memory_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// MEM stage with MEM/WB pipeline register: issues loads/stores over a req/ack bus,
// stalls upstream while waiting, formats load data and registers results for writeback.
module memory_stage #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 ex_reg_write,
  input  logic [1:0]           ex_wb_sel,
  input  logic [4:0]           ex_rd,
  input  logic [31:0]          ex_alu_result,
  input  logic [31:0]          ex_store_data,
  input  logic                 ex_mem_read,
  input  logic                 ex_mem_write,
  input  logic [2:0]           ex_funct3,
  input  logic                 flush,
  output logic                 mem_stall,
  memory_stage_if.master       dmem,
  output logic                 wb_valid,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic [4:0]           rd,
  output logic [31:0]          alu_result,
  output logic [31:0]          memory_data,
  output logic                 mem_misaligned,
  output logic                 mem_fault
);

  localparam int unsigned CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          kill_q, kill_d;

  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;

  logic [31:0]   l_alu_q, l_alu_d;
  logic [2:0]    l_f3_q, l_f3_d;
  logic [4:0]    l_rd_q, l_rd_d;
  logic [1:0]    l_wbsel_q, l_wbsel_d;
  logic          l_rw_q, l_rw_d;
  logic          l_load_q, l_load_d;

  logic          wb_valid_q, wb_valid_d;
  logic          reg_write_q, reg_write_d;
  logic [1:0]    wb_sel_q, wb_sel_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   alu_q, alu_d;
  logic [31:0]   mdata_q, mdata_d;
  logic          mis_q, mis_d;
  logic          fault_q, fault_d;

  logic          memop, misaligned, timeout, kill_now;
  logic [31:0]   st_wdata, ld_data;
  logic [3:0]    st_wstrb;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  // funct3[1:0]: 00 byte, 01 half, 1x word; funct3[2] selects zero-extension.
  assign memop      = ex_valid & ~flush & (ex_mem_read | ex_mem_write);
  assign misaligned = ((ex_funct3[1:0] == 2'b01) & ex_alu_result[0]) |
                      (ex_funct3[1] & (ex_alu_result[1:0] != 2'b00));
  assign timeout    = (ACK_TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = ex_store_data;
    case (ex_funct3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << ex_alu_result[1:0];
        st_wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        st_wstrb = 4'b0011 << {ex_alu_result[1], 1'b0};
        st_wdata = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = '0;
    case (l_alu_q[1:0])
      2'd0: ld_byte = dmem.dmem_rdata[7:0];
      2'd1: ld_byte = dmem.dmem_rdata[15:8];
      2'd2: ld_byte = dmem.dmem_rdata[23:16];
      2'd3: ld_byte = dmem.dmem_rdata[31:24];
      default: ;
    endcase
    ld_half = l_alu_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (l_f3_q[1:0])
      2'b00:   ld_data = {{24{~l_f3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~l_f3_q[2] & ld_half[15]}}, ld_half};
      default: ld_data = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kill_d      = kill_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    l_alu_d     = l_alu_q;
    l_f3_d      = l_f3_q;
    l_rd_d      = l_rd_q;
    l_wbsel_d   = l_wbsel_q;
    l_rw_d      = l_rw_q;
    l_load_d    = l_load_q;
    wb_valid_d  = 1'b0;
    reg_write_d = 1'b0;
    wb_sel_d    = '0;
    rd_d        = '0;
    alu_d       = '0;
    mdata_d     = '0;
    mis_d       = 1'b0;
    fault_d     = 1'b0;
    mem_stall   = 1'b0;
    kill_now    = kill_q | flush;

    case (state_q)
      S_IDLE: begin
        if (memop && !misaligned) begin
          mem_stall = 1'b1;
          state_d   = S_WAIT;
          cnt_d     = '0;
          kill_d    = 1'b0;
          req_d     = 1'b1;
          we_d      = ex_mem_write;
          addr_d    = {ex_alu_result[31:2], 2'b00};
          wdata_d   = ex_mem_write ? st_wdata : '0;
          wstrb_d   = ex_mem_write ? st_wstrb : '0;
          l_alu_d   = ex_alu_result;
          l_f3_d    = ex_funct3;
          l_rd_d    = ex_rd;
          l_wbsel_d = ex_wb_sel;
          l_rw_d    = ex_reg_write;
          l_load_d  = ~ex_mem_write;
        end else if (ex_valid && !flush) begin
          wb_valid_d  = 1'b1;
          wb_sel_d    = ex_wb_sel;
          rd_d        = ex_rd;
          alu_d       = ex_alu_result;
          mis_d       = memop;
          reg_write_d = ex_reg_write & ~memop;
        end
      end
      S_WAIT: begin
        // A flush seen at any point during the wait is remembered; the bus
        // transaction still runs to completion but retires as a bubble.
        kill_d = kill_now;
        if (dmem.dmem_ack || timeout) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = '0;
          if (!kill_now) begin
            wb_valid_d = 1'b1;
            wb_sel_d   = l_wbsel_q;
            rd_d       = l_rd_q;
            alu_d      = l_alu_q;
            if (dmem.dmem_ack) begin
              reg_write_d = l_rw_q & l_load_q;
              mdata_d     = l_load_q ? ld_data : '0;
            end else begin
              fault_d = 1'b1;
            end
          end
        end else begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      kill_q      <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      l_alu_q     <= '0;
      l_f3_q      <= '0;
      l_rd_q      <= '0;
      l_wbsel_q   <= '0;
      l_rw_q      <= 1'b0;
      l_load_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      reg_write_q <= 1'b0;
      wb_sel_q    <= '0;
      rd_q        <= '0;
      alu_q       <= '0;
      mdata_q     <= '0;
      mis_q       <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kill_q      <= kill_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      l_alu_q     <= l_alu_d;
      l_f3_q      <= l_f3_d;
      l_rd_q      <= l_rd_d;
      l_wbsel_q   <= l_wbsel_d;
      l_rw_q      <= l_rw_d;
      l_load_q    <= l_load_d;
      wb_valid_q  <= wb_valid_d;
      reg_write_q <= reg_write_d;
      wb_sel_q    <= wb_sel_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      mdata_q     <= mdata_d;
      mis_q       <= mis_d;
      fault_q     <= fault_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = wstrb_q;

  assign wb_valid       = wb_valid_q;
  assign reg_write      = reg_write_q & wb_valid_q;
  assign wb_sel         = wb_sel_q;
  assign rd             = rd_q;
  assign alu_result     = alu_q;
  assign memory_data    = mdata_q;
  assign mem_misaligned = mis_q;
  assign mem_fault      = fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass-through, loads/stores, misalignment,
// ack timeout, flush and reset during a pending memory access.
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, flush;
  logic [1:0]  ex_wb_sel;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [2:0]  ex_funct3;
  logic        mem_stall, wb_valid, reg_write, mem_misaligned, mem_fault;
  logic [1:0]  wb_sel;
  logic [4:0]  rd;
  logic [31:0] alu_result, memory_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  memory_stage_if bus ();

  memory_stage #(.ACK_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_reg_write   (ex_reg_write),
    .ex_wb_sel      (ex_wb_sel),
    .ex_rd          (ex_rd),
    .ex_alu_result  (ex_alu_result),
    .ex_store_data  (ex_store_data),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_funct3      (ex_funct3),
    .flush          (flush),
    .mem_stall      (mem_stall),
    .dmem           (bus.master),
    .wb_valid       (wb_valid),
    .reg_write      (reg_write),
    .wb_sel         (wb_sel),
    .rd             (rd),
    .alu_result     (alu_result),
    .memory_data    (memory_data),
    .mem_misaligned (mem_misaligned),
    .mem_fault      (mem_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic v, input logic rw, input logic [1:0] sel, input logic [4:0] d,
                        input logic [31:0] alu, input logic [31:0] sd, input logic mr,
                        input logic mw, input logic [2:0] f3);
    ex_valid      = v;
    ex_reg_write  = rw;
    ex_wb_sel     = sel;
    ex_rd         = d;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_funct3     = f3;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    set_op(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0, 3'b000);
    tick();
    tick();
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_alu", alu_result, 32'h0);
    rst = 1'b0;
    tick();

    // ALU op: single-cycle pass to MEM/WB
    set_op(1, 1, 2'b00, 5'd5, 32'h1234, 32'h0, 0, 0, 3'b000);
    #1 chk("alu_stall", 32'(mem_stall), 32'd0);
    tick();
    chk("alu_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu_reg_write", 32'(reg_write), 32'd1);
    chk("alu_result", alu_result, 32'h1234);
    chk("alu_rd", 32'(rd), 32'd5);
    chk("alu_no_req", 32'(bus.dmem_req), 32'd0);
    set_op(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0, 3'b000);
    tick();
    chk("bubble_wb_valid", 32'(wb_valid), 32'd0);

    // LB at 0x1003, ack one cycle after req
    set_op(1, 1, 2'b01, 5'd7, 32'h1003, 32'h0, 1, 0, 3'b000);
    #1 chk("lb_stall0", 32'(mem_stall), 32'd1);
    tick();
    chk("lb_req", 32'(bus.dmem_req), 32'd1);
    chk("lb_addr", bus.dmem_addr, 32'h1000);
    chk("lb_we", 32'(bus.dmem_we), 32'd0);
    chk("lb_wstrb", 32'(bus.dmem_wstrb), 32'd0);
    chk("lb_bubble", 32'(wb_valid), 32'd0);
    chk("lb_stall1", 32'(mem_stall), 32'd1);
    tick();
    chk("lb_req_held", 32'(bus.dmem_req), 32'd1);
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h80FF_FF00;
    #1 chk("lb_stall2", 32'(mem_stall), 32'd0);
    tick();
    bus.dmem_ack = 1'b0;
    set_op(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0, 3'b000);
    chk("lb_req_drop", 32'(bus.dmem_req), 32'd0);
    chk("lb_wb_valid", 32'(wb_valid), 32'd1);
    chk("lb_reg_write", 32'(reg_write), 32'd1);
    chk("lb_rd", 32'(rd), 32'd7);
    chk("lb_data", memory_data, 32'hFFFF_FF80);

    // LBU at 0x1003, ack on the earliest edge
    set_op(1, 1, 2'b01, 5'd8, 32'h1003, 32'h0, 1, 0, 3'b100);
    tick();
    chk("lbu_req", 32'(bus.dmem_req), 32'd1);
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;
    set_op(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0, 3'b000);
    chk("lbu_wb_valid", 32'(wb_valid), 32'd1);
    chk("lbu_data", memory_data, 32'h0000_0080);

    // LH at 0x6002, upper half sign-extended
    set_op(1, 1, 2'b01, 5'd9, 32'h6002, 32'h0, 1, 0, 3'b001);
    tick();
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h8001_7FFF;
    tick();
    bus.dmem_ack = 1'b0;
    set_op(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0, 3'b000);
    chk("lh_data", memory_data, 32'hFFFF_8001);

    // SH 0xABCD at 0x2002
    set_op(1, 1, 2'b00, 5'd3, 32'h2002, 32'h1234_ABCD, 0, 1, 3'b001);
    tick();
    chk("sh_addr", bus.dmem_addr, 32'h2000);
    chk("sh_wstrb", 32'(bus.dmem_wstrb), 32'hC);
    chk("sh_wdata", bus.dmem_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(bus.dmem_we), 32'd1);
    tick();
    chk("sh_wstrb_held", 32'(bus.dmem_wstrb), 32'hC);
    chk("sh_addr_held", bus.dmem_addr, 32'h2000);
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;
    set_op(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0, 3'b000);
    chk("sh_wb_valid", 32'(wb_valid), 32'd1);
    chk("sh_reg_write", 32'(reg_write), 32'd0);
    chk("sh_req_drop", 32'(bus.dmem_req), 32'd0);

    // SB at 0x7001
    set_op(1, 0, 2'b00, 5'd0, 32'h7001, 32'h0000_005A, 0, 1, 3'b000);
    tick();
    chk("sb_wstrb", 32'(bus.dmem_wstrb), 32'h2);
    chk("sb_wdata", bus.dmem_wdata, 32'h5A5A_5A5A);
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;
    set_op(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0, 3'b000);

    // LW at 0x3001: misaligned, no memory op
    set_op(1, 1, 2'b01, 5'd4, 32'h3001, 32'h0, 1, 0, 3'b010);
    #1 chk("mis_stall", 32'(mem_stall), 32'd0);
    tick();
    set_op(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0, 3'b000);
    chk("mis_no_req", 32'(bus.dmem_req), 32'd0);
    chk("mis_flag", 32'(mem_misaligned), 32'd1);
    chk("mis_wb_valid", 32'(wb_valid), 32'd1);
    chk("mis_reg_write", 32'(reg_write), 32'd0);
    tick();
    chk("mis_pulse_end", 32'(mem_misaligned), 32'd0);

    // ack while idle is ignored
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;
    chk("idle_ack_wb", 32'(wb_valid), 32'd0);
    chk("idle_ack_req", 32'(bus.dmem_req), 32'd0);

    // LW with ack withheld: req high 4 cycles, then fault
    set_op(1, 1, 2'b01, 5'd6, 32'h4000, 32'h0, 1, 0, 3'b010);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req_%0d", i), 32'(bus.dmem_req), 32'd1);
      chk($sformatf("to_stall_%0d", i), 32'(mem_stall), (i == 3) ? 32'd0 : 32'd1);
      tick();
    end
    set_op(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0, 3'b000);
    chk("to_req_drop", 32'(bus.dmem_req), 32'd0);
    chk("to_fault", 32'(mem_fault), 32'd1);
    chk("to_wb_valid", 32'(wb_valid), 32'd1);
    chk("to_reg_write", 32'(reg_write), 32'd0);
    tick();
    chk("to_fault_end", 32'(mem_fault), 32'd0);

    // flush during WAIT, then ack: retires as a bubble
    set_op(1, 1, 2'b01, 5'd9, 32'h5000, 32'h0, 1, 0, 3'b010);
    tick();
    flush = 1'b1;
    #1 chk("fw_stall", 32'(mem_stall), 32'd1);
    tick();
    flush = 1'b0;
    chk("fw_req_held", 32'(bus.dmem_req), 32'd1);
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;
    set_op(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0, 3'b000);
    chk("fw_wb_valid", 32'(wb_valid), 32'd0);
    chk("fw_reg_write", 32'(reg_write), 32'd0);
    chk("fw_req_drop", 32'(bus.dmem_req), 32'd0);

    // flush in IDLE discards a memop
    set_op(1, 1, 2'b01, 5'd9, 32'h5000, 32'h0, 1, 0, 3'b010);
    flush = 1'b1;
    #1 chk("fi_stall", 32'(mem_stall), 32'd0);
    tick();
    flush = 1'b0;
    set_op(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0, 3'b000);
    chk("fi_req", 32'(bus.dmem_req), 32'd0);
    chk("fi_wb_valid", 32'(wb_valid), 32'd0);

    // reset mid-WAIT drops req asynchronously
    set_op(1, 1, 2'b01, 5'd2, 32'h6000, 32'h0, 1, 0, 3'b010);
    tick();
    chk("rw_req", 32'(bus.dmem_req), 32'd1);
    #2;
    rst = 1'b1;
    set_op(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0, 3'b000);
    #1 chk("rw_req_async", 32'(bus.dmem_req), 32'd0);
    chk("rw_stall", 32'(mem_stall), 32'd0);
    tick();
    rst = 1'b0;
    set_op(1, 1, 2'b00, 5'd11, 32'hCAFE, 32'h0, 0, 0, 3'b000);
    #1 chk("rw_idle_stall", 32'(mem_stall), 32'd0);
    tick();
    set_op(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0, 3'b000);
    chk("rw_idle_pass", alu_result, 32'hCAFE);
    chk("rw_idle_valid", 32'(wb_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
